// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: state encoding, writeback
// select codes and default timeout sizing.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    localparam int DEFAULT_TIMEOUT = 15;
    localparam int DEFAULT_CNT_W   = 4;

    // Writeback source mux; the reserved code 2'b11 falls back to the ALU path.
    function automatic logic [15:0] wb_pick(input logic [1:0]  sel,
                                            input logic [15:0] alu_v,
                                            input logic [15:0] mem_v,
                                            input logic [15:0] pc_v);
        logic [15:0] res;
        res = alu_v;
        if (sel == WB_MEM) begin
            res = mem_v;
        end else if (sel == WB_PC) begin
            res = pc_v;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the memory stage (master)
// and the multi-cycle data memory (slave).
interface mem_stage_ctrl_if;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_timeout_cnt.sv
// Busy-cycle counter for the memory stage. Clear has priority over enable;
// expired_o flags the count value at which one more missing ack is fatal.
module mem_timeout_cnt #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count BUSY cycles without an acknowledge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage controller: issues loads/stores over a req/ack bus, stalls
// upstream while busy, retires a registered writeback value with a one-cycle
// valid pulse and latches halt/error conditions.
// Optional feature macro: MEM_ALIGN_CHECK_EN (odd load/store address -> ERR).
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              halt,
    input  logic [15:0]       alu_final,
    input  logic [15:0]       add_pc,
    input  logic [15:0]       st_data,
    input  logic [1:0]        wb_sel,
    mem_stage_ctrl_if.master  mem,
    output logic              stall,
    output logic              wb_valid,
    output logic [15:0]       wb_data,
    output logic              halted,
    output logic              err
);

    state_e      state_q;
    logic        req_q;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [1:0]  sel_q;
    logic [15:0] pc_q;
    logic        wb_valid_q;
    logic [15:0] wb_data_q;
    logic        halted_q;
    logic        err_q;

    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_expired;

    // Counter sits at zero while idle so every access starts from a fresh count.
    assign cnt_clr = (state_q == ST_IDLE);
    assign cnt_en  = (state_q == ST_BUSY) && !mem.mem_ack;

    mem_timeout_cnt #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (cnt_expired)
    );

    // Main FSM with registered bus, writeback and sticky status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= WB_ALU;
            pc_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ex_valid) begin
                        if (halt) begin
                            state_q  <= ST_HALTED;
                            halted_q <= 1'b1;
                        end else if (mem_read && mem_write) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else if (mem_read || mem_write) begin
`ifdef MEM_ALIGN_CHECK_EN
                            if (alu_final[0]) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end else
`endif
                            begin
                                addr_q  <= alu_final;
                                wdata_q <= st_data;
                                sel_q   <= wb_sel;
                                pc_q    <= add_pc;
                                wr_q    <= mem_write;
                                req_q   <= 1'b1;
                                state_q <= ST_BUSY;
                            end
                        end else begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= wb_pick(wb_sel, alu_final, alu_final, add_pc);
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem.mem_ack) begin
                        req_q      <= 1'b0;
                        state_q    <= ST_IDLE;
                        wb_valid_q <= 1'b1;
                        // Stores always retire the address they wrote.
                        wb_data_q  <= wb_pick(wr_q ? WB_ALU : sel_q, addr_q,
                                              mem.mem_rdata, pc_q);
                    end else if (cnt_expired) begin
                        req_q   <= 1'b0;
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end
                end
                ST_HALTED: begin
                end
                ST_ERR: begin
                end
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_wr    = wr_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign stall    = (state_q != ST_IDLE);
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign halted   = halted_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed plus randomized bench for mem_stage_ctrl. Expected results come
// from an instruction-level model: each instruction's outcome (retire value,
// bus activity, busy length, sticky flags) is computed from the block's rules.
module tb_mem_stage_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] alu_final = '0;
    logic [15:0] add_pc = '0;
    logic [15:0] st_data = '0;
    logic [1:0]  wb_sel = '0;
    logic        stall;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        halted;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_stage_ctrl_if mif ();

    mem_stage_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .halt      (halt),
        .alu_final (alu_final),
        .add_pc    (add_pc),
        .st_data   (st_data),
        .wb_sel    (wb_sel),
        .mem       (mif),
        .stall     (stall),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference rules for the retired value.
    function automatic logic [15:0] ref_alu_wb(input logic [1:0] sel, input logic [15:0] alu,
                                              input logic [15:0] pc);
        return (sel == 2'b10) ? pc : alu;
    endfunction

    function automatic logic [15:0] ref_mem_wb(input logic is_wr, input logic [1:0] sel,
                                              input logic [15:0] addr, input logic [15:0] rdata,
                                              input logic [15:0] pc);
        if (is_wr)            return addr;
        else if (sel == 2'b01) return rdata;
        else if (sel == 2'b10) return pc;
        else                   return addr;
    endfunction

    task automatic idle_inputs();
        ex_valid      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        halt          = 1'b0;
        alu_final     = 16'($urandom);
        add_pc        = 16'($urandom);
        st_data       = 16'($urandom);
        wb_sel        = 2'($urandom);
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 16'($urandom);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        chk("rst_mem_req", 16'(mif.mem_req), 16'd0);
        chk("rst_mem_wr", 16'(mif.mem_wr), 16'd0);
        chk("rst_mem_addr", mif.mem_addr, 16'd0);
        chk("rst_mem_wdata", mif.mem_wdata, 16'd0);
        chk("rst_stall", 16'(stall), 16'd0);
        chk("rst_wb_valid", 16'(wb_valid), 16'd0);
        chk("rst_wb_data", wb_data, 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        rst_n = 1'b1;
    endtask

    task automatic gap(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) begin
            step();
            chk("gap_wb_valid", 16'(wb_valid), 16'd0);
            chk("gap_stall", 16'(stall), 16'd0);
            chk("gap_mem_req", 16'(mif.mem_req), 16'd0);
        end
    endtask

    task automatic issue_nonmem(input logic [15:0] alu, input logic [15:0] pc, input logic [1:0] sel);
        logic [15:0] exp;
        exp = ref_alu_wb(sel, alu, pc);
        ex_valid  = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        halt      = 1'b0;
        alu_final = alu;
        add_pc    = pc;
        wb_sel    = sel;
        step();
        idle_inputs();
        chk("alu_wb_valid", 16'(wb_valid), 16'd1);
        chk("alu_wb_data", wb_data, exp);
        chk("alu_stall", 16'(stall), 16'd0);
        chk("alu_mem_req", 16'(mif.mem_req), 16'd0);
        $display("ALU  sel=%b alu=%h pc=%h -> wb_data=%h (expect %h)", sel, alu, pc, wb_data, exp);
    endtask

    // One load/store lasting 'busy' BUSY cycles, acknowledged in the last one.
    task automatic issue_mem(input logic is_wr, input logic [15:0] addr, input logic [15:0] sd,
                             input logic [15:0] pc, input logic [1:0] sel, input int busy,
                             input logic [15:0] rdata);
        logic [15:0] exp;
        exp = ref_mem_wb(is_wr, sel, addr, rdata, pc);
        ex_valid  = 1'b1;
        mem_read  = !is_wr;
        mem_write = is_wr;
        halt      = 1'b0;
        alu_final = addr;
        st_data   = sd;
        add_pc    = pc;
        wb_sel    = sel;
        step();
        idle_inputs();
        for (int i = 1; i <= busy; i++) begin
            chk("busy_mem_req", 16'(mif.mem_req), 16'd1);
            chk("busy_mem_wr", 16'(mif.mem_wr), 16'(is_wr));
            chk("busy_mem_addr", mif.mem_addr, addr);
            chk("busy_mem_wdata", mif.mem_wdata, sd);
            chk("busy_stall", 16'(stall), 16'd1);
            chk("busy_wb_valid", 16'(wb_valid), 16'd0);
            if (i == busy) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = rdata;
            end
            step();
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = 16'($urandom);
        end
        chk("ret_wb_valid", 16'(wb_valid), 16'd1);
        chk("ret_wb_data", wb_data, exp);
        chk("ret_mem_req", 16'(mif.mem_req), 16'd0);
        chk("ret_stall", 16'(stall), 16'd0);
        $display("%s addr=%h sel=%b busy=%0d -> wb_data=%h (expect %h)",
                 is_wr ? "ST  " : "LD  ", addr, sel, busy, wb_data, exp);
    endtask

    initial begin
        logic [15:0] a;
        logic [1:0]  s;
        int          kind;

        idle_inputs();
        do_reset();
        gap(2);

        // Acknowledge while idle is ignored.
        mif.mem_ack = 1'b1;
        step();
        mif.mem_ack = 1'b0;
        chk("stray_ack_wb_valid", 16'(wb_valid), 16'd0);
        chk("stray_ack_mem_req", 16'(mif.mem_req), 16'd0);
        chk("stray_ack_stall", 16'(stall), 16'd0);

        // Non-memory instructions, including back-to-back retirement.
        issue_nonmem(16'h1234, 16'h0002, 2'b00);
        issue_nonmem(16'h5555, 16'h0104, 2'b10);
        issue_nonmem(16'h6666, 16'h0106, 2'b01);
        issue_nonmem(16'h7777, 16'h0108, 2'b11);
        gap(1);

        // Directed loads/stores.
        issue_mem(1'b0, 16'h0040, 16'h0000, 16'h0200, 2'b01, 3, 16'hBEEF);
        gap(1);
        issue_mem(1'b1, 16'h0010, 16'hA5A5, 16'h0202, 2'b00, 1, 16'h0000);
        gap(1);
        issue_mem(1'b0, 16'h0080, 16'h1111, 16'h0300, 2'b10, TO, 16'hCAFE);
        gap(1);
        issue_mem(1'b0, 16'h00A0, 16'h2222, 16'h0302, 2'b00, 2, 16'hD00D);
        gap(1);

        // Odd address.
`ifdef MEM_ALIGN_CHECK_EN
        ex_valid  = 1'b1;
        mem_read  = 1'b1;
        alu_final = 16'h0003;
        step();
        idle_inputs();
        chk("align_mem_req", 16'(mif.mem_req), 16'd0);
        chk("align_err", 16'(err), 16'd1);
        chk("align_stall", 16'(stall), 16'd1);
        $display("ALIGN odd load -> err=%0d mem_req=%0d", err, mif.mem_req);
        do_reset();
`else
        issue_mem(1'b0, 16'h0003, 16'h3333, 16'h0400, 2'b01, 2, 16'h4321);
        gap(1);
`endif

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 3));
            a = 16'($urandom);
`ifdef MEM_ALIGN_CHECK_EN
            a[0] = 1'b0;
`endif
            if (kind < 2) begin
                issue_nonmem(a, 16'($urandom), 2'($urandom));
            end else if (kind == 2) begin
                issue_mem(1'b0, a, 16'($urandom), 16'($urandom), 2'($urandom),
                          int'($urandom_range(1, TO)), 16'($urandom));
            end else begin
                s = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
                issue_mem(1'b1, a, 16'($urandom), 16'($urandom), s,
                          int'($urandom_range(1, TO)), 16'($urandom));
            end
            gap(int'($urandom_range(0, 2)));
        end

        // Timeout: a load never acknowledged.
        ex_valid  = 1'b1;
        mem_read  = 1'b1;
        alu_final = 16'h0042;
        step();
        idle_inputs();
        for (int i = 1; i <= TO; i++) begin
            chk("to_busy_mem_req", 16'(mif.mem_req), 16'd1);
            chk("to_busy_err", 16'(err), 16'd0);
            step();
        end
        chk("to_err", 16'(err), 16'd1);
        chk("to_mem_req", 16'(mif.mem_req), 16'd0);
        chk("to_stall", 16'(stall), 16'd1);
        $display("TIMEOUT after %0d busy cycles -> err=%0d mem_req=%0d", TO, err, mif.mem_req);
        for (int i = 0; i < 4; i++) begin
            ex_valid    = 1'b1;
            mem_read    = 1'b1;
            alu_final   = 16'h0100;
            mif.mem_ack = 1'(i);
            step();
            chk("err_hold_err", 16'(err), 16'd1);
            chk("err_hold_stall", 16'(stall), 16'd1);
            chk("err_hold_req", 16'(mif.mem_req), 16'd0);
            chk("err_hold_halted", 16'(halted), 16'd0);
            chk("err_hold_wb_valid", 16'(wb_valid), 16'd0);
        end
        do_reset();

        // Halt takes priority over memory controls and is absorbing.
        ex_valid  = 1'b1;
        halt      = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        step();
        idle_inputs();
        chk("halt_halted", 16'(halted), 16'd1);
        chk("halt_stall", 16'(stall), 16'd1);
        chk("halt_err", 16'(err), 16'd0);
        chk("halt_wb_valid", 16'(wb_valid), 16'd0);
        $display("HALT -> halted=%0d stall=%0d", halted, stall);
        for (int i = 0; i < 3; i++) begin
            ex_valid  = 1'b1;
            mem_read  = 1'b1;
            alu_final = 16'h0020;
            step();
            chk("halt_hold_req", 16'(mif.mem_req), 16'd0);
            chk("halt_hold_halted", 16'(halted), 16'd1);
            chk("halt_hold_wb_valid", 16'(wb_valid), 16'd0);
        end
        do_reset();

        // Load and store together is an error.
        ex_valid  = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b1;
        step();
        idle_inputs();
        chk("rdwr_err", 16'(err), 16'd1);
        chk("rdwr_halted", 16'(halted), 16'd0);
        chk("rdwr_mem_req", 16'(mif.mem_req), 16'd0);
        chk("rdwr_stall", 16'(stall), 16'd1);
        $display("RD+WR -> err=%0d", err);
        do_reset();

        // Reset in the middle of an access drops the request.
        ex_valid  = 1'b1;
        mem_write = 1'b1;
        alu_final = 16'h0050;
        step();
        idle_inputs();
        chk("abort_pre_req", 16'(mif.mem_req), 16'd1);
        do_reset();
        $display("ABORT by reset -> mem_req=%0d", mif.mem_req);
        gap(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory stage placed directly downstream of the execute stage. Consumes the execute results (ALU result, link PC, store data) and the decoded memory controls.
- Drives a multi-cycle data memory through a req/ack handshake, stalls the upstream pipeline while an access is outstanding, and produces a registered writeback value with a one-cycle valid pulse.
- Also latches halt and error conditions for the top level.

Parameters:
- TIMEOUT, 15: maximum BUSY cycles without mem_ack before the block enters ERR; legal range 1..15.
- CNT_W, 4: width of the timeout counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- ex_valid  in  1  an execute result is presented this cycle
- mem_read  in  1  load instruction
- mem_write  in  1  store instruction
- halt  in  1  HALT instruction
- alu_final  in  16  execute result; also the memory address
- add_pc  in  16  link/next PC from execute
- st_data  in  16  store data
- wb_sel  in  2  writeback source: 00 ALU, 01 memory, 10 PC, 11 reserved (treated as ALU)
- mem_rdata  in  16  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion
- mem_req  out  1  memory request, held until ack
- mem_wr  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  16  registered address
- mem_wdata  out  16  registered store data
- stall  out  1  upstream must hold its outputs
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_data  out  16  registered writeback value
- halted  out  1  sticky halt flag
- err  out  1  sticky error flag

Behaviour:
- Reset (rst_n low at a clock edge):
  - state IDLE.
  - mem_req, mem_wr, stall, wb_valid, halted and err are 0.
  - mem_addr, mem_wdata, wb_data and the counter are 0.
  - Reset mid-access aborts it; mem_req drops at that edge.
- States: IDLE, BUSY, HALTED, ERR (2-bit encoding).
- stall = 1 in BUSY, HALTED and ERR; 0 in IDLE. stall is a function of state only.
- IDLE, ex_valid=0: no change, wb_valid=0.
- IDLE, ex_valid=1, halt=1: go to HALTED and set halted. No writeback pulse. Halt takes priority over memory controls.
- IDLE, ex_valid=1, mem_read=1 and mem_write=1: go to ERR and set err.
- IDLE, ex_valid=1, non-memory instruction:
  - Next edge: wb_valid=1.
  - wb_data = add_pc if wb_sel=10, otherwise alu_final. Latency 1.
- IDLE, ex_valid=1, exactly one of mem_read/mem_write:
  - Capture alu_final into mem_addr, st_data into mem_wdata, and wb_sel and add_pc internally.
  - mem_wr = mem_write; mem_req=1; counter=0; go to BUSY.
- BUSY, mem_ack=1: next edge:
  - mem_req=0, go to IDLE, wb_valid=1.
  - wb_data = mem_rdata if captured wb_sel=01; captured add_pc if 10; mem_addr otherwise.
  - Stores retire with wb_valid=1 and wb_data=mem_addr.
- BUSY, mem_ack=0: counter increments.
  - If counter == TIMEOUT-1 at that edge: go to ERR, mem_req=0, err=1.
  - Minimum load/store latency is 2 cycles: accept edge, then ack edge.
- While BUSY, ex_* inputs are ignored; upstream holds them and they are accepted in the first IDLE cycle.
- mem_ack while not BUSY is ignored.
- HALTED and ERR are absorbing until reset. wb_valid stays 0. ERR also keeps halted=0.
- wb_valid is never high for two consecutive cycles on a memory op. Back-to-back non-memory instructions may pulse wb_valid on every cycle.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a load/store accepted in IDLE with alu_final[0]=1 raises no mem_req. The block goes directly to ERR with err=1.
- Undefined: the address is passed unmodified and no alignment check exists. Logic is absent.

Decomposition:
- Package mem_stage_pkg:
  - state encoding constants (IDLE=0, BUSY=1, HALTED=2, ERR=3);
  - WB_ALU, WB_MEM, WB_PC select constants;
  - default TIMEOUT.
- One sub-module, mem_timeout_cnt: a CNT_W-bit counter with clear, enable and an expiry output at TIMEOUT-1.

Test Plan:
- ADD result, ex_valid=1, wb_sel=00, alu_final=16'h1234 -> next cycle wb_valid=1, wb_data=16'h1234, stall stays 0.
- Load with alu_final=16'h0040, mem_ack after 3 BUSY cycles with mem_rdata=16'hBEEF:
  - mem_req/mem_addr=16'h0040/mem_wr=0 held and stall=1 for 3 cycles;
  - then wb_valid=1, wb_data=16'hBEEF, state IDLE.
- Store with alu_final=16'h0010, st_data=16'hA5A5, immediate ack -> mem_wr=1, mem_wdata=16'hA5A5, one BUSY cycle, wb_valid pulse, mem_req low afterward.
- Load, mem_ack never asserted, TIMEOUT=15 -> err=1 after 15 BUSY cycles, mem_req=0, stall=1 permanently; rst_n low clears everything.
- HALT with ex_valid=1 -> halted=1 and stall=1 next cycle; later ex_valid loads issue no mem_req.
- With MEM_ALIGN_CHECK_EN defined, load at 16'h0003 -> no mem_req, err=1 next cycle. Without the macro, mem_addr=16'h0003 is issued normally.
